// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- raster timing generator for a VGA-style display.
//
// Walks a (hdata, vdata) position through a HMAX x VMAX raster, one pixel per
// clk with ce=1, and produces registered sync/visible flags plus one-clk event
// pulses that all describe the position shown on hdata/vdata in the same cycle.
//
// Ports:
//   clk          single clock
//   rst          synchronous active-high reset (parks at the last raster pixel)
//   ce           pixel clock enable; one pixel advance per clk while high
//   hdata/vdata  current horizontal / vertical position
//   hsync/vsync  sync outputs, active level set by HSPP / VSPP (1 = positive)
//   data_enable  high while the position lies in the visible area
//   line_start   one-clk pulse when hdata newly becomes 0
//   frame_start  one-clk pulse when the position newly becomes (0,0)
//   vblank_start one-clk pulse when the position newly becomes (0,VSIZE)
//   addr         linear framebuffer address of the current visible pixel
//
// Build option: define VGA_TIMING_ADDR_EN to include the address counter;
// without it addr is tied to 0.
module vga_timing_gen #(
  parameter int WIDTH      = 12,
  parameter int HSIZE      = 800,
  parameter int HFP        = 856,
  parameter int HSP        = 976,
  parameter int HMAX       = 1040,
  parameter int VSIZE      = 600,
  parameter int VFP        = 637,
  parameter int VSP        = 643,
  parameter int VMAX       = 666,
  parameter int HSPP       = 1,
  parameter int VSPP       = 1,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  output logic [WIDTH-1:0]      hdata,
  output logic [WIDTH-1:0]      vdata,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  data_enable,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  vblank_start,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [WIDTH-1:0] H_LAST  = WIDTH'(HMAX - 1);
  localparam logic [WIDTH-1:0] V_LAST  = WIDTH'(VMAX - 1);
  localparam logic [WIDTH-1:0] HSIZE_W = WIDTH'(HSIZE);
  localparam logic [WIDTH-1:0] HFP_W   = WIDTH'(HFP);
  localparam logic [WIDTH-1:0] HSP_W   = WIDTH'(HSP);
  localparam logic [WIDTH-1:0] VSIZE_W = WIDTH'(VSIZE);
  localparam logic [WIDTH-1:0] VFP_W   = WIDTH'(VFP);
  localparam logic [WIDTH-1:0] VSP_W   = WIDTH'(VSP);
  localparam logic             HS_ON   = (HSPP != 0);
  localparam logic             VS_ON   = (VSPP != 0);

  // Sync level for a position: active inside [lo, hi), inactive elsewhere.
  function automatic logic sync_level(input logic [WIDTH-1:0] pos,
                                      input logic [WIDTH-1:0] lo,
                                      input logic [WIDTH-1:0] hi,
                                      input logic             on);
    return ((pos >= lo) && (pos < hi)) ? on : ~on;
  endfunction

  logic [WIDTH-1:0] h_nxt_p0;
  logic [WIDTH-1:0] v_nxt_p0;
  logic             vis_nxt_p0;
  logic             vld_p0;

  // ---- stage p0: next raster position, decoded before it is registered ----
  // All outputs are computed from this next position so that, once registered,
  // they describe the same pixel as hdata/vdata.
  always_comb begin
    vld_p0   = ce;
    h_nxt_p0 = hdata + ONE_W;
    v_nxt_p0 = vdata;
    if (hdata == H_LAST) begin
      h_nxt_p0 = '0;
      v_nxt_p0 = (vdata == V_LAST) ? '0 : (vdata + ONE_W);
    end
    vis_nxt_p0 = (h_nxt_p0 < HSIZE_W) && (v_nxt_p0 < VSIZE_W);
  end

  // ---- stage p1: registered position, levels and pulses ----
  // Reset parks on the last raster pixel so the first enabled advance lands on
  // (0,0) and naturally raises frame_start and line_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdata        <= H_LAST;
      vdata        <= V_LAST;
      hsync        <= ~HS_ON;
      vsync        <= ~VS_ON;
      data_enable  <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else if (vld_p0) begin
      hdata        <= h_nxt_p0;
      vdata        <= v_nxt_p0;
      hsync        <= sync_level(h_nxt_p0, HFP_W, HSP_W, HS_ON);
      vsync        <= sync_level(v_nxt_p0, VFP_W, VSP_W, VS_ON);
      data_enable  <= vis_nxt_p0;
      line_start   <= (h_nxt_p0 == '0);
      frame_start  <= (h_nxt_p0 == '0) && (v_nxt_p0 == '0);
      vblank_start <= (h_nxt_p0 == '0) && (v_nxt_p0 == VSIZE_W);
    end else begin
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_ADDR_EN
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  // Visible pixels are visited in raster order, so counting visible advances
  // yields vdata*HSIZE+hdata without a multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (vld_p0) begin
      if ((h_nxt_p0 == '0) && (v_nxt_p0 == '0)) begin
        addr <= '0;
      end else if (vis_nxt_p0) begin
        addr <= addr + ADDR_ONE;
      end
    end
  end
`else
  assign addr = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  localparam int WIDTH = 12;
  localparam int AW    = 19;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ce  = 1'b0;
  logic [WIDTH-1:0] hdata, vdata;
  logic            hsync, vsync, data_enable;
  logic            line_start, frame_start, vblank_start;
  logic [AW-1:0]   addr;

  int total = 0;
  int bad   = 0;

  vga_timing_gen #(
    .WIDTH(WIDTH), .HSIZE(4), .HFP(5), .HSP(6), .HMAX(8),
    .VSIZE(3), .VFP(4), .VSP(5), .VMAX(6),
    .HSPP(1), .VSPP(0), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .hdata(hdata), .vdata(vdata),
    .hsync(hsync), .vsync(vsync), .data_enable(data_enable),
    .line_start(line_start), .frame_start(frame_start), .vblank_start(vblank_start),
    .addr(addr)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ce  = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    step();
    total++; if (hdata !== 12'd7) begin bad++; $display("FAIL reset_h got=%0d want=7", hdata); end
    total++; if (vdata !== 12'd5) begin bad++; $display("FAIL reset_v got=%0d want=5", vdata); end
    total++; if (data_enable !== 1'b0) begin bad++; $display("FAIL reset_de got=%b want=0", data_enable); end
    total++; if (hsync !== 1'b0) begin bad++; $display("FAIL reset_hsync got=%b want=0", hsync); end
    total++; if (vsync !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b want=1", vsync); end
    total++; if ({line_start, frame_start, vblank_start} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses got=%b want=000", {line_start, frame_start, vblank_start}); end
    total++; if (addr !== '0) begin bad++; $display("FAIL reset_addr got=%0d want=0", addr); end
    rst = 1'b0;
  endtask

  // Three full frames with ce held high; expectations derived from the cycle
  // index k since the first advance (position k mod 48 in an 8x6 raster).
  task automatic test_free_run();
    int h, v, p, de_cnt, exp_addr;
    logic exp_de;
    do_reset();
    ce = 1'b1;
    de_cnt   = 0;
    exp_addr = 0;
    for (int k = 0; k < 144; k++) begin
      step();
      p = k % 48;
      h = p % 8;
      v = p / 8;
      exp_de = (h < 4) && (v < 3);
      if (p == 0) exp_addr = 0;
      else if (exp_de) exp_addr = v * 4 + h;
      if (exp_de && k < 48) de_cnt++;
      total++; if (hdata !== WIDTH'(h)) begin bad++; $display("FAIL run_h k=%0d got=%0d want=%0d", k, hdata, h); end
      total++; if (vdata !== WIDTH'(v)) begin bad++; $display("FAIL run_v k=%0d got=%0d want=%0d", k, vdata, v); end
      total++; if (hsync !== (h == 5)) begin bad++; $display("FAIL run_hsync k=%0d got=%b want=%b", k, hsync, (h == 5)); end
      total++; if (vsync !== (v != 4)) begin bad++; $display("FAIL run_vsync k=%0d got=%b want=%b", k, vsync, (v != 4)); end
      total++; if (data_enable !== exp_de) begin bad++; $display("FAIL run_de k=%0d got=%b want=%b", k, data_enable, exp_de); end
      total++; if (line_start !== (h == 0)) begin bad++; $display("FAIL run_line_start k=%0d got=%b want=%b", k, line_start, (h == 0)); end
      total++; if (frame_start !== (p == 0)) begin bad++; $display("FAIL run_frame_start k=%0d got=%b want=%b", k, frame_start, (p == 0)); end
      total++; if (vblank_start !== (p == 24)) begin bad++; $display("FAIL run_vblank k=%0d got=%b want=%b", k, vblank_start, (p == 24)); end
`ifdef VGA_TIMING_ADDR_EN
      total++; if (addr !== AW'(exp_addr)) begin bad++; $display("FAIL run_addr k=%0d got=%0d want=%0d", k, addr, exp_addr); end
`else
      total++; if (addr !== '0) begin bad++; $display("FAIL run_addr_tied k=%0d got=%0d want=0", k, addr); end
`endif
    end
    total++; if (de_cnt != 12) begin bad++; $display("FAIL de_count got=%0d want=12", de_cnt); end
  endtask

  // From (7,2) the next advance enters the first blanking line.
  task automatic test_vblank();
    do_reset();
    ce = 1'b1;
    for (int i = 0; i < 24; i++) step();
    total++; if ({hdata, vdata} !== {12'd7, 12'd2}) begin
      bad++; $display("FAIL vb_pre got=(%0d,%0d) want=(7,2)", hdata, vdata); end
    step();
    total++; if ({hdata, vdata} !== {12'd0, 12'd3}) begin
      bad++; $display("FAIL vb_pos got=(%0d,%0d) want=(0,3)", hdata, vdata); end
    total++; if ({vblank_start, line_start, frame_start, data_enable} !== 4'b1100) begin
      bad++; $display("FAIL vb_flags got=%b want=1100", {vblank_start, line_start, frame_start, data_enable}); end
    step();
    total++; if ({vblank_start, line_start} !== 2'b00) begin
      bad++; $display("FAIL vb_one_clk got=%b want=00", {vblank_start, line_start}); end
  endtask

  task automatic test_ce_toggle();
    do_reset();
    ce = 1'b1; step();
    total++; if ({hdata, vdata, frame_start, line_start, data_enable} !== {12'd0, 12'd0, 3'b111}) begin
      bad++; $display("FAIL ce_first got=(%0d,%0d) fs=%b ls=%b de=%b want=(0,0) 111", hdata, vdata, frame_start, line_start, data_enable); end
    ce = 1'b0; step();
    total++; if ({hdata, vdata} !== {12'd0, 12'd0}) begin
      bad++; $display("FAIL ce_hold0 got=(%0d,%0d) want=(0,0)", hdata, vdata); end
    total++; if ({frame_start, line_start, vblank_start, data_enable} !== 4'b0001) begin
      bad++; $display("FAIL ce_pulse_drop got=%b want=0001", {frame_start, line_start, vblank_start, data_enable}); end
    total++; if (addr !== '0) begin bad++; $display("FAIL ce_addr_hold0 got=%0d want=0", addr); end
    ce = 1'b1; step();
    total++; if ({hdata, vdata, frame_start, line_start} !== {12'd1, 12'd0, 2'b00}) begin
      bad++; $display("FAIL ce_adv1 got=(%0d,%0d) fs=%b ls=%b want=(1,0) 00", hdata, vdata, frame_start, line_start); end
    ce = 1'b0; step();
    total++; if ({hdata, vdata} !== {12'd1, 12'd0}) begin
      bad++; $display("FAIL ce_hold1 got=(%0d,%0d) want=(1,0)", hdata, vdata); end
`ifdef VGA_TIMING_ADDR_EN
    total++; if (addr !== AW'(1)) begin bad++; $display("FAIL ce_addr_hold1 got=%0d want=1", addr); end
`endif
  endtask

  task automatic test_mid_reset();
    do_reset();
    ce = 1'b1;
    for (int i = 0; i < 11; i++) step();
    total++; if ({hdata, vdata} !== {12'd2, 12'd1}) begin
      bad++; $display("FAIL mr_pre got=(%0d,%0d) want=(2,1)", hdata, vdata); end
    rst = 1'b1; step();
    total++; if ({hdata, vdata} !== {12'd7, 12'd5}) begin
      bad++; $display("FAIL mr_pos got=(%0d,%0d) want=(7,5)", hdata, vdata); end
    total++; if ({data_enable, vsync, hsync} !== 3'b010) begin
      bad++; $display("FAIL mr_levels got=%b want=010", {data_enable, vsync, hsync}); end
    total++; if (addr !== '0) begin bad++; $display("FAIL mr_addr got=%0d want=0", addr); end
    rst = 1'b0; step();
    total++; if ({hdata, vdata, frame_start} !== {12'd0, 12'd0, 1'b1}) begin
      bad++; $display("FAIL mr_restart got=(%0d,%0d) fs=%b want=(0,0) 1", hdata, vdata, frame_start); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_vblank();
    test_ce_toggle();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter WIDTH, 12, bit width of hdata/vdata.
REQ-002 SHALL have parameter HSIZE, 800, visible pixels per line.
REQ-003 SHALL have parameter HFP, 856, first hcount of hsync pulse.
REQ-004 SHALL have parameter HSP, 976, first hcount after hsync pulse.
REQ-005 SHALL have parameter HMAX, 1040, hcounts per line.
REQ-006 SHALL have parameters VSIZE 600, VFP 637, VSP 643, VMAX 666, the vertical equivalents in lines.
REQ-007 SHALL have parameters HSPP 1 and VSPP 1, the active sync polarity (0 negative, 1 positive).
REQ-008 SHALL have parameter ADDR_WIDTH, 19, bit width of addr.
REQ-009 SHALL have port clk, input, 1, the single clock.
REQ-010 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-011 SHALL have port ce, input, 1, pixel clock enable; one pixel advance per clk with ce=1.
REQ-012 SHALL have port hdata, output, WIDTH, current horizontal position.
REQ-013 SHALL have port vdata, output, WIDTH, current vertical position.
REQ-014 SHALL have ports hsync, vsync, data_enable, output, 1 each, registered sync and visible flags.
REQ-015 SHALL have ports line_start, frame_start, vblank_start, output, 1 each, one-clk event pulses.
REQ-016 SHALL have port addr, output, ADDR_WIDTH, linear framebuffer address of the current pixel.

Function
REQ-017 With ce=1, hdata SHALL increment and wrap from HMAX-1 to 0; vdata SHALL increment only on that wrap, and SHALL wrap from VMAX-1 to 0.
REQ-018 With ce=0, all counters and level outputs SHALL hold and all pulses SHALL be 0.
REQ-019 hsync, vsync and data_enable SHALL be registers computed from the next position, and so describe the same pixel as hdata/vdata in the same cycle; there SHALL be no combinational path to the outputs.
REQ-020 hsync SHALL equal HSPP when HFP<=hdata<HSP, else !HSPP; vsync SHALL follow the same rule with VFP, VSP and VSPP.
REQ-021 data_enable SHALL be 1 exactly when hdata<HSIZE and vdata<VSIZE.
REQ-022 line_start SHALL be 1 for exactly the cycle in which hdata newly equals 0.
REQ-023 frame_start SHALL be 1 for exactly the cycle in which the position newly equals (0,0).
REQ-024 vblank_start SHALL be 1 for exactly the cycle in which the position newly equals (0,VSIZE).
REQ-025 Whenever data_enable=1, addr SHALL equal vdata*HSIZE+hdata, truncated to ADDR_WIDTH.
REQ-026 addr SHALL become 0 on frame_start, SHALL increment on each advance into a visible pixel other than (0,0), and SHALL hold otherwise.
REQ-027 The block SHALL assume HSIZE<=HFP<HSP<=HMAX-1 and VSIZE<=VFP<VSP<=VMAX-1; behaviour outside these ranges is unspecified.

Reset
REQ-028 While rst=1, the block SHALL set hdata=HMAX-1, vdata=VMAX-1, data_enable=0, hsync=!HSPP, vsync=!VSPP, all pulses 0 and addr=0, and SHALL ignore ce.
REQ-029 The first ce=1 cycle after rst falls SHALL advance to (0,0) and assert frame_start and line_start.
REQ-030 rst asserted mid-frame SHALL return the block to the REQ-028 state on the next clk edge.

Configuration
REQ-031 With macro VGA_TIMING_ADDR_EN defined, the block SHALL implement addr as in REQ-025 and REQ-026.
REQ-032 Without VGA_TIMING_ADDR_EN, addr SHALL be constant 0 and the block SHALL contain no address counter; all other behaviour SHALL be unchanged.

Verification
All scenarios use the small test configuration: HSIZE=4, HFP=5, HSP=6, HMAX=8, VSIZE=3, VFP=4, VSP=5, VMAX=6, HSPP=1, VSPP=0.
REQ-033 Reset, then ce=1 held -> cycle 1 shows (0,0), data_enable=1, frame_start=1, line_start=1; frame_start recurs every 48 clk.
REQ-034 ce=1 held -> hsync=1 only at hdata=5; vsync=0 only at vdata=4; data_enable high for 12 of every 48 clk.
REQ-035 With the macro defined, ce=1 held -> addr reads 0,1,2,3 on line 0, 4..7 on line 1 and 8..11 on line 2, then holds 11 until the next frame_start resets it to 0.
REQ-036 ce toggled 1,0,1,0 -> position advances every other clk, and pulses last 1 clk only.
REQ-037 rst pulsed at (2,1) -> next cycle hdata=7, vdata=5, data_enable=0, vsync=1; the next ce advances to (0,0) with frame_start=1.
REQ-038 At (7,2) with ce=1 -> next cycle shows (0,3), vblank_start=1, line_start=1, data_enable=0.
